// File: rtl/rx_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_assembler
//  Description : Serial receive frame assembler. It consumes one voted bit per
//                Sample_Available strobe and walks start, DATA_WIDTH data
//                bits (LSB first), an optional parity bit and a stop bit. One
//                cycle after the stop strobe it reports exactly one result
//                pulse: data_valid (P_DATA loaded), par_err or stp_err.
//                Optional feature macro: RX_BREAK_DET_EN adds a break_det
//                output that flags an all-zero frame in place of the error
//                pulses.
//                DATA_WIDTH must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_assembler #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Sample_Available,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
`ifdef RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  frame_active
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                  state_q,        state_d;
    logic [DATA_WIDTH-1:0]   shift_q,        shift_d;
    logic [c_cnt_w-1:0]      cnt_q,          cnt_d;
    logic                    par_en_q,       par_en_d;
    logic                    par_typ_q,      par_typ_d;
    logic                    par_mis_q,      par_mis_d;
    logic [DATA_WIDTH-1:0]   p_data_q,       p_data_d;
    logic                    data_valid_q,   data_valid_d;
    logic                    par_err_q,      par_err_d;
    logic                    stp_err_q,      stp_err_d;
    logic                    frame_active_q, frame_active_d;
    logic                    w_is_break;
`ifdef RX_BREAK_DET_EN
    logic                    par_bit_q,      par_bit_d;
    logic                    break_det_q,    break_det_d;
`endif

    // Break condition: every bit of the frame after the start bit was 0.
    // The stored parity bit stays 0 when parity is disabled.
    always_comb begin
`ifdef RX_BREAK_DET_EN
        w_is_break = (shift_q == '0) && !par_bit_q && !sampled_bit;
`else
        w_is_break = 1'b0;
`endif
    end

    // Next-state logic: everything holds unless a sample strobe arrives;
    // result pulses default low so each lasts a single cycle.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        par_mis_d      = par_mis_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        par_err_d      = 1'b0;
        stp_err_d      = 1'b0;
`ifdef RX_BREAK_DET_EN
        par_bit_d      = par_bit_q;
        break_det_d    = 1'b0;
`endif
        if (Sample_Available) begin
            case (state_q)
                IDLE: begin
                    // A 0 is a start bit; a 1 is idle line or a false start.
                    if (!sampled_bit) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        shift_d   = '0;
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                        par_mis_d = 1'b0;
`ifdef RX_BREAK_DET_EN
                        par_bit_d = 1'b0;
`endif
                    end
                end
                DATA: begin
                    // Shift in from the top so the first bit ends at bit 0.
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = cnt_q + c_cnt_one;
                    if (cnt_q == c_last_bit) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_mis_d = sampled_bit != ((^shift_q) ^ par_typ_q);
`ifdef RX_BREAK_DET_EN
                    par_bit_d = sampled_bit;
`endif
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (w_is_break) begin
`ifdef RX_BREAK_DET_EN
                        break_det_d = 1'b1;
`endif
                    end else if (!sampled_bit) begin
                        stp_err_d = 1'b1;
                    end else if (par_mis_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Registered so it falls together with the result pulse.
        frame_active_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_mis_q      <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            par_err_q      <= 1'b0;
            stp_err_q      <= 1'b0;
            frame_active_q <= 1'b0;
`ifdef RX_BREAK_DET_EN
            par_bit_q      <= 1'b0;
            break_det_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            par_mis_q      <= par_mis_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            par_err_q      <= par_err_d;
            stp_err_q      <= stp_err_d;
            frame_active_q <= frame_active_d;
`ifdef RX_BREAK_DET_EN
            par_bit_q      <= par_bit_d;
            break_det_q    <= break_det_d;
`endif
        end
    end

    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign par_err      = par_err_q;
    assign stp_err      = stp_err_q;
    assign frame_active = frame_active_q;
`ifdef RX_BREAK_DET_EN
    assign break_det    = break_det_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_frame_assembler
//  Description : Self-checking bench for rx_frame_assembler. Frames are built
//                from a data word plus explicit parity/stop bits; the expected
//                outcome is computed from the frame rules and compared with
//                the DUT outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_assembler;

    localparam int c_tag_none  = 0;
    localparam int c_tag_start = 1;
    localparam int c_tag_mid   = 2;
    localparam int c_tag_stop  = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Sample_Available = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       frame_active;
`ifdef RX_BREAK_DET_EN
    logic       break_det;
`endif

    // Expected-output model state
    logic       exp_dv = 1'b0, exp_pe = 1'b0, exp_se = 1'b0, exp_bk = 1'b0;
    logic       exp_active = 1'b0;
    logic [7:0] exp_pdata = 8'h00;
    // Outcome of the frame currently being sent
    logic       pend_dv, pend_pe, pend_se, pend_bk;
    logic [7:0] pend_data;

    int  checks = 0;
    int  errors = 0;
    bit  cmp_en = 1'b0;

    rx_frame_assembler #(.DATA_WIDTH(8)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .Sample_Available (Sample_Available),
        .sampled_bit      (sampled_bit),
        .PAR_EN           (PAR_EN),
        .PAR_TYP          (PAR_TYP),
        .P_DATA           (P_DATA),
        .data_valid       (data_valid),
        .par_err          (par_err),
        .stp_err          (stp_err),
`ifdef RX_BREAK_DET_EN
        .break_det        (break_det),
`endif
        .frame_active     (frame_active)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            cmp("data_valid",   {31'd0, data_valid},   {31'd0, exp_dv});
            cmp("par_err",      {31'd0, par_err},      {31'd0, exp_pe});
            cmp("stp_err",      {31'd0, stp_err},      {31'd0, exp_se});
            cmp("frame_active", {31'd0, frame_active}, {31'd0, exp_active});
            cmp("P_DATA",       {24'd0, P_DATA},       {24'd0, exp_pdata});
`ifdef RX_BREAK_DET_EN
            cmp("break_det",    {31'd0, break_det},    {31'd0, exp_bk});
`endif
        end
    end

    // One clock cycle, optionally carrying a strobe; the model is updated
    // just after the edge according to the role of the strobe in the frame.
    task automatic tick(input logic sa, input logic b, input int tag);
        @(negedge CLK);
        Sample_Available = sa;
        sampled_bit      = b;
        @(posedge CLK);
        #1;
        Sample_Available = 1'b0;
        exp_dv = 1'b0; exp_pe = 1'b0; exp_se = 1'b0; exp_bk = 1'b0;
        if (sa && tag == c_tag_start) exp_active = 1'b1;
        if (sa && tag == c_tag_stop) begin
            exp_active = 1'b0;
            exp_dv = pend_dv; exp_pe = pend_pe; exp_se = pend_se; exp_bk = pend_bk;
            if (pend_dv) exp_pdata = pend_data;
        end
    endtask

    // Full frame: start, 8 data bits LSB first, optional parity, stop.
    // gap idle cycles separate strobes; toggle flips PAR_EN/PAR_TYP after
    // the start bit, which must not affect the frame.
    task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                              input logic pbit, input logic stopb, input int gap,
                              input logic toggle);
        logic mism;
        mism      = pen && (pbit != ((^data) ^ ptyp));
        pend_bk   = 1'b0;
`ifdef RX_BREAK_DET_EN
        pend_bk   = (data == 8'h00) && !(pen && pbit) && !stopb;
`endif
        pend_se   = !pend_bk && !stopb;
        pend_pe   = !pend_bk && stopb && mism;
        pend_dv   = !pend_bk && stopb && !mism;
        pend_data = data;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        tick(1'b1, 1'b0, c_tag_start);
        if (toggle) begin
            PAR_EN  = ~pen;
            PAR_TYP = ~ptyp;
        end
        for (int i = 0; i < 8; i++) begin
            repeat (gap) tick(1'b0, 1'b1, c_tag_none);
            tick(1'b1, data[i], c_tag_mid);
        end
        if (pen) begin
            repeat (gap) tick(1'b0, 1'b0, c_tag_none);
            tick(1'b1, pbit, c_tag_mid);
        end
        repeat (gap) tick(1'b0, 1'b0, c_tag_none);
        tick(1'b1, stopb, c_tag_stop);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST = 1'b0;
        Sample_Available = 1'b0;
        exp_dv = 1'b0; exp_pe = 1'b0; exp_se = 1'b0; exp_bk = 1'b0;
        exp_active = 1'b0;
        exp_pdata  = 8'h00;
        repeat (2) @(negedge CLK);
        #2;
        RST = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        RST = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge CLK);
        cmp("lit_reset_pdata", {24'd0, P_DATA}, 32'h0);
        cmp("lit_reset_active", {31'd0, frame_active}, 32'h0);
        #2;
        RST = 1'b1;
        tick(1'b0, 1'b1, c_tag_none);

        // 0xA5, even parity, correct parity bit 0
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        cmp("lit_a5_valid", {31'd0, data_valid}, 32'h1);
        cmp("lit_a5_pdata", {24'd0, P_DATA}, 32'hA5);

        // 0x3C, odd parity, wrong parity bit 0 -> parity error, P_DATA held
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        cmp("lit_3c_par_err", {31'd0, par_err}, 32'h1);
        cmp("lit_3c_pdata", {24'd0, P_DATA}, 32'hA5);

        // 0x0F, no parity, stop bit 0 -> stop error
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cmp("lit_0f_stp_err", {31'd0, stp_err}, 32'h1);
        cmp("lit_0f_valid", {31'd0, data_valid}, 32'h0);

        // Idle strobes ignored, then back-to-back 0x55 and 0xAA
        repeat (3) tick(1'b1, 1'b1, c_tag_none);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        cmp("lit_55_pdata", {24'd0, P_DATA}, 32'h55);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        cmp("lit_aa_pdata", {24'd0, P_DATA}, 32'hAA);

        // Strobes separated by idle cycles, odd parity correct (bit 1)
        send_frame(8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        cmp("lit_96_pdata", {24'd0, P_DATA}, 32'h96);

        // Parity settings flipped mid-frame must be ignored
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        send_frame(8'hC4, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b1);

        // Stop error takes priority over a parity mismatch
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Reset after the 4th data strobe aborts the frame silently
        PAR_EN = 1'b0;
        tick(1'b1, 1'b0, c_tag_start);
        for (int i = 0; i < 4; i++) tick(1'b1, i[0], c_tag_mid);
        do_reset();
        repeat (2) tick(1'b0, 1'b1, c_tag_none);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        cmp("lit_81_pdata", {24'd0, P_DATA}, 32'h81);

        // All-zero frame without parity
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
`ifdef RX_BREAK_DET_EN
        cmp("lit_break_det", {31'd0, break_det}, 32'h1);
`else
        cmp("lit_zero_stp_err", {31'd0, stp_err}, 32'h1);
`endif
        cmp("lit_zero_pdata", {24'd0, P_DATA}, 32'h81);

        repeat (3) tick(1'b0, 1'b1, c_tag_none);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
